vram_write_sched: RTL
=====================

// Module: vram_write_sched
// PURPOSE
//  Sequences the VRAM write port. Sweeps the 640x480 write raster (h_addr/l_addr) at CLK_DIV-cycle pixel pace,
//  issues the one-cycle write strobe and selects pixel data from the block-mode or text-mode renderer.
//  Mode changes and board snapshots are applied only between frames, so a displayed frame never mixes sources.
//  Sits between the renderers (board combiner, block renderer, text renderer) and the VGA I/O RAM write port.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel write slot (>=3)
//  H_PIX     640  pixels per line
//  V_LIN     480  lines per frame
// PORTS
//  clk        in   1   system clock (100MHz)
//  rst        in   1   synchronous reset, active-high
//  mode_req   in   1   requested source: 0 block/game, 1 text
//  blk_data   in   2   block renderer pixel, valid 1 clk after address change
//  txt_data   in   2   text renderer pixel, valid 1 clk after address change
//  snap_ack   in   1   board snapshot latched by combiner
//  snap_req   out  1   request combiner to latch new board
//  h_addr     out  9   write row 0..V_LIN-1
//  l_addr     out  10  write col 0..H_PIX-1
//  load       out  1   VRAM write enable, one clk per pixel slot
//  data       out  2   VRAM write data
//  mode_cur   out  1   mode in effect for current frame
//  frame_done out  1   one-clk pulse after last pixel of a frame written
// BEHAVIOUR
//  Reset (clk edge with rst=1): FSM->IDLE; all outputs 0; phase counter 0; mode_cur 0. rst overrides everything,
//   including mid-frame: sweep aborts, next frame restarts at (0,0).
//  FSM: IDLE -> SNAP (next clk). SNAP: snap_req=1, held until snap_ack=1; on that clk latch mode_cur<=mode_req,
//   drop snap_req, -> SWEEP at (0,0). snap_ack while not in SNAP is ignored.
//  SWEEP: phase counter 0..CLK_DIV-1. Phase 0: address stable (updated on prior slot end). Phase 2: load=1,
//   data = mode_cur ? txt_data : blk_data (registered; 2 clk after address, covers 1-clk renderer latency).
//   Phase CLK_DIV-1: advance l_addr; at H_PIX-1 wrap to 0 and increment h_addr; at (V_LIN-1,H_PIX-1) -> DONE.
//  DONE: frame_done=1 one clk, h_addr/l_addr return to 0, -> SNAP.
//  load is 0 outside SWEEP phase 2; data holds last value when load=0.
//  mode_req changes mid-frame are ignored until next SNAP; mode_req sampled only on snap_ack clk.
//  Frame period in SWEEP = H_PIX*V_LIN*CLK_DIV clk; SNAP adds >=1 clk, DONE 1 clk.
//  Address counters never exceed H_PIX-1 / V_LIN-1; widths fixed at 10/9 bits.
// CONFIGURATION
//  VRAM_CLEAR_EN defined: after reset, FSM enters CLEAR before IDLE; one full sweep with load at phase 2 and
//   data=2'b00, snap_req held 0, frame_done not pulsed; then IDLE. rst during CLEAR restarts CLEAR.
//  Undefined: reset goes straight to IDLE; VRAM contents left as-is.
// TESTING
//  1 rst high 3 clk, release, snap_ack tied 1 -> snap_req at clk 1, first load at (0,0) phase 2, outputs 0 in reset.
//  2 mode_req=0, blk_data=2'b11, txt_data=2'b01 -> every load carries 2'b11; count loads=307200 before frame_done.
//  3 toggle mode_req to 1 mid-frame -> mode_cur stays 0 until next snap_ack; next frame writes 2'b01.
//  4 hold snap_ack=0 for 50 clk -> snap_req stays 1, load stays 0, addresses stay (0,0); ack -> sweep starts.
//  5 assert rst at (h=100,l=300) -> next clk all outputs 0; after release sweep restarts at (0,0).
//  6 VRAM_CLEAR_EN: after reset 307200 loads with data 00 before first snap_req; without macro snap_req at clk 1.

Source files
------------

// File: rtl/vram_write_sched.sv
// VRAM write-port sequencer: sweeps the write raster one pixel slot at a time and picks block or text pixels.
// Optional build macro VRAM_CLEAR_EN adds a post-reset pass that writes 2'b00 to the whole raster before the first frame.
module vram_write_sched #(
    parameter int CLK_DIV = 4,
    parameter int H_PIX   = 640,
    parameter int V_LIN   = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_req,
    input  logic [1:0] blk_data,
    input  logic [1:0] txt_data,
    input  logic       snap_ack,
    output logic       snap_req,
    output logic [8:0] h_addr,
    output logic [9:0] l_addr,
    output logic       load,
    output logic [1:0] data,
    output logic       mode_cur,
    output logic       frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(1);
    localparam logic [PW-1:0] PH_LOAD   = PW'(2);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [9:0]    L_LAST    = 10'(H_PIX - 1);
    localparam logic [8:0]    H_LAST    = 9'(V_LIN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNAP  = 3'd1,
        S_SWEEP = 3'd2,
        S_DONE  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

`ifdef VRAM_CLEAR_EN
    localparam state_t RST_STATE = S_CLEAR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase;
    logic          sweeping;
    logic          slot_end;
    logic          last_pix;
    logic [1:0]    pix_p0;

    // CLEAR walks the raster exactly like SWEEP; only the data source and the exit differ
    assign sweeping = (state == S_SWEEP) || (state == S_CLEAR);
    assign slot_end = sweeping && (phase == PH_LAST);
    assign last_pix = slot_end && (h_addr == H_LAST) && (l_addr == L_LAST);
    assign pix_p0   = (state == S_CLEAR) ? 2'b00 : (mode_cur ? txt_data : blk_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_SNAP;
            S_SNAP:  if (snap_ack) state_nxt = S_SWEEP;
            S_SWEEP: if (last_pix) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_SNAP;
            S_CLEAR: if (last_pix) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        snap_req   = (state == S_SNAP);
        frame_done = (state == S_DONE);
        load       = sweeping && (phase == PH_LOAD);
    end

    // Address moves at slot end, renderers answer one clk later, pixel is registered at the end of phase 1
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            h_addr   <= '0;
            l_addr   <= '0;
            data     <= '0;
            mode_cur <= 1'b0;
        end else begin
            if ((state == S_SNAP) && snap_ack) begin
                mode_cur <= mode_req;
            end
            if (sweeping) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end else begin
                phase <= '0;
            end
            if (slot_end) begin
                if (l_addr == L_LAST) begin
                    l_addr <= '0;
                    h_addr <= (h_addr == H_LAST) ? '0 : h_addr + 1'b1;
                end else begin
                    l_addr <= l_addr + 1'b1;
                end
            end
            if (sweeping && (phase == PH_SAMPLE)) begin
                data <= pix_p0;
            end
        end
    end

endmodule
